mips_dmem_responder: RTL and testbench

- Data-side memory responder for the pipelined MIPS core. Sits on the other end of the core's data port: `memwrite`, `memaddr`, `memwritedata`, `memreaddata`.
- Decodes each access to one of two targets:
  - word-addressed data RAM;
  - a small MMIO page: LED register, byte TX FIFO with status, cycle counter.
- Read data is returned combinationally in the same cycle, because the core captures it into its MEM/WB register at the end of the MEM cycle.
- The TX FIFO drains to an external byte consumer over a valid/ready handshake.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_tx_fifo.sv | 73 +++++++
 rtl/mips_dmem_responder.sv | 136 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the MIPS data-memory responder: MMIO offsets,
// STATUS bit positions and the default MMIO page.
package dmem_pkg;

    localparam logic [1:0]  OFF_LED    = 2'd0;
    localparam logic [1:0]  OFF_TXDATA = 2'd1;
    localparam logic [1:0]  OFF_STATUS = 2'd2;
    localparam logic [1:0]  OFF_CYCLES = 2'd3;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    localparam logic [15:0] MMIO_PAGE_DEFAULT = 16'hFFFF;

    function automatic logic [31:0] status_word(input logic [3:0] cnt,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w = 32'd0;
        w[STAT_CNT_LSB +: 4] = cnt;
        w[STAT_OVF]          = ovf;
        w[STAT_FULL]         = full;
        w[STAT_EMPTY]        = empty;
        return w;
    endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Circular-buffer byte FIFO feeding the TX consumer; head reads 0 when empty
// and a push into a full FIFO is accepted only alongside a pop.
module dmem_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == {(PW+1){1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Head byte, forced to zero while empty
    always_comb begin
        head = {WIDTH{1'b0}};
        if (!empty) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = {WIDTH{1'b0}};
        end
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the pipelined MIPS core: word RAM plus an
// MMIO page (LED, TX FIFO, STATUS, CYCLES). CYCLES exists only when
// DMEM_CYCLE_COUNTER_EN is defined; otherwise it reads 0.
module mips_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_AW     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_r [2**RAM_AW];
    logic [7:0]        led_r;
    logic              ovf_r;
    logic              is_mmio_s;
    logic [1:0]        off_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              wr_ram_s;
    logic              wr_led_s;
    logic              wr_tx_s;
    logic              wr_status_s;
    logic              wr_cycles_s;
    logic              pop_s;
    logic [7:0]        fifo_head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CW-1:0]     fifo_count_s;
    logic [4:0]        count_ext_s;
    logic [31:0]       cycles_s;
    logic              unused_s;

    assign is_mmio_s   = (memaddr[31:16] == MMIO_PAGE);
    assign off_s       = memaddr[3:2];
    assign ram_idx_s   = memaddr[RAM_AW+1:2];
    assign wr_ram_s    = memwrite && !is_mmio_s && !reset;
    assign wr_led_s    = memwrite && is_mmio_s && (off_s == OFF_LED);
    assign wr_tx_s     = memwrite && is_mmio_s && (off_s == OFF_TXDATA);
    assign wr_status_s = memwrite && is_mmio_s && (off_s == OFF_STATUS);
    assign wr_cycles_s = memwrite && is_mmio_s && (off_s == OFF_CYCLES);
    assign pop_s       = tx_valid && tx_ready;
    assign count_ext_s = 5'(fifo_count_s);
    assign led         = led_r;
    assign tx_data     = fifo_head_s;
    assign tx_valid    = !fifo_empty_s;
    assign unused_s    = ^{memaddr, memwritedata};

    dmem_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_tx_s && !reset),
        .push_data (memwritedata[7:0]),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    // Word RAM write port; reads are asynchronous so same-cycle reads see old data
    always_ff @(posedge clk) begin
        if (wr_ram_s) begin
            ram_r[ram_idx_s] <= memwritedata;
        end
    end

    // LED register and sticky overflow; a STATUS write wins over a new overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'd0;
            ovf_r <= 1'b0;
        end else begin
            if (wr_led_s) begin
                led_r <= memwritedata[7:0];
            end
            if (wr_status_s) begin
                ovf_r <= 1'b0;
            end else if (wr_tx_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycles_r;

    // Free-running cycle counter; the write cycle itself also counts
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_r <= 32'd0;
        end else if (wr_cycles_s) begin
            cycles_r <= memwritedata + 32'd1;
        end else begin
            cycles_r <= cycles_r + 32'd1;
        end
    end

    assign cycles_s = cycles_r;
`else
    logic unused_cycles_s;
    assign unused_cycles_s = wr_cycles_s;
    assign cycles_s        = 32'd0;
`endif

    // Combinational read mux; the core latches it at the end of MEM
    always_comb begin
        memreaddata = 32'd0;
        if (is_mmio_s) begin
            case (off_s)
                OFF_LED:    memreaddata = {24'd0, led_r};
                OFF_TXDATA: memreaddata = 32'd0;
                OFF_STATUS: memreaddata = status_word(count_ext_s[3:0], ovf_r,
                                                      fifo_full_s, fifo_empty_s);
                OFF_CYCLES: memreaddata = cycles_s;
                default:    memreaddata = 32'd0;
            endcase
        end else begin
            memreaddata = ram_r[ram_idx_s];
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: vector table for RAM/LED/FIFO
// fill, a byte scoreboard on the TX port and hand sequences for corner cases.
module tb_mips_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] sb_q[$];

    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_TX  = 32'hFFFF_0004;
    localparam logic [31:0] A_ST  = 32'hFFFF_0008;
    localparam logic [31:0] A_CY  = 32'hFFFF_000C;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_led;
        logic [7:0]  exp_led;
        logic        push_exp;
    } vec_t;

    vec_t tbl[15];

    mips_dmem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .led          (led),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge
    task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
        @(posedge clk);
        #1;
        memwrite     = we;
        memaddr      = addr;
        memwritedata = wd;
        tx_ready     = rdy;
        @(negedge clk);
    endtask

    // Scoreboard: every accepted TX byte must match the oldest expected byte
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                check("tx_unexpected_pop", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0,          1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'd0,         1'b1, 32'hDEAD_BEEF,  1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0410, 32'd0,         1'b1, 32'hDEAD_BEEF,  1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0013, 32'd0,         1'b1, 32'hDEAD_BEEF,  1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, A_LED,         32'h0000_01A5, 1'b0, 32'd0,          1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, A_LED,         32'd0,         1'b1, 32'h0000_00A5,  1'b1, 8'hA5, 1'b0};
        tbl[6]  = '{1'b1, A_TX,          32'h0000_0011, 1'b0, 32'd0,          1'b0, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, A_TX,          32'h0000_0022, 1'b0, 32'd0,          1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b1, A_TX,          32'h0000_0033, 1'b0, 32'd0,          1'b0, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, A_TX,          32'h0000_0044, 1'b0, 32'd0,          1'b0, 8'h00, 1'b1};
        tbl[10] = '{1'b1, A_TX,          32'h0000_0055, 1'b0, 32'd0,          1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, A_ST,          32'd0,         1'b1, 32'h0000_0046,  1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b0, A_TX,          32'd0,         1'b1, 32'h0000_0000,  1'b0, 8'h00, 1'b0};
        tbl[13] = '{1'b1, A_ST,          32'h1234_5678, 1'b0, 32'd0,          1'b0, 8'h00, 1'b0};
        tbl[14] = '{1'b0, A_ST,          32'd0,         1'b1, 32'h0000_0042,  1'b1, 8'hA5, 1'b0};

        reset = 1'b1; memwrite = 1'b0; memaddr = 32'd0; memwritedata = 32'd0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        cyc(1'b0, A_ST, 32'd0, 1'b0);
        check("reset_status", memreaddata, 32'h0000_0001);
        check("reset_led", {24'd0, led}, 32'd0);
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0);
            if (tbl[i].push_exp) sb_q.push_back(tbl[i].wd[7:0]);
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), memreaddata, tbl[i].exp_rd);
            if (tbl[i].chk_led) check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
        end
        check("full_head", {24'd0, tx_data}, 32'h0000_0011);

        // Push into a full FIFO while the consumer pops: accepted
        cyc(1'b1, A_TX, 32'h0000_0066, 1'b1);
        sb_q.push_back(8'h66);
        cyc(1'b0, A_ST, 32'd0, 1'b0);
        check("full_simul_status", memreaddata, 32'h0000_0042);
        check("full_simul_head", {24'd0, tx_data}, 32'h0000_0022);

        for (int i = 0; i < 10 && tx_valid; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
        check("drain_valid", {31'd0, tx_valid}, 32'd0);
        check("drain_sb_empty", sb_q.size(), 32'd0);
        cyc(1'b0, A_ST, 32'd0, 1'b0);
        check("drain_status", memreaddata, 32'h0000_0001);

        // No bypass: byte appears one cycle after the push
        cyc(1'b1, A_TX, 32'h0000_0077, 1'b0);
        sb_q.push_back(8'h77);
        check("push_cycle_valid", {31'd0, tx_valid}, 32'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0);
        check("next_cycle_valid", {31'd0, tx_valid}, 32'd1);
        check("next_cycle_data", {24'd0, tx_data}, 32'h0000_0077);

        // Streaming push/pop across several pointer wraps
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, A_TX, 32'h80 + 32'(i), 1'b1);
            sb_q.push_back(8'h80 + 8'(i));
        end
        for (int i = 0; i < 10 && tx_valid; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
        check("wrap_sb_empty", sb_q.size(), 32'd0);
        check("wrap_valid", {31'd0, tx_valid}, 32'd0);

`ifdef DMEM_CYCLE_COUNTER_EN
        cyc(1'b0, A_CY, 32'd0, 1'b0);
        c1 = memreaddata;
        repeat (9) cyc(1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, A_CY, 32'd0, 1'b0);
        c2 = memreaddata;
        check("cycles_delta", c2 - c1, 32'd10);
        cyc(1'b1, A_CY, 32'hFFFF_FFFE, 1'b0);
        cyc(1'b0, A_CY, 32'd0, 1'b0);
        check("cycles_pre_wrap", memreaddata, 32'hFFFF_FFFF);
        cyc(1'b0, A_CY, 32'd0, 1'b0);
        check("cycles_wrap", memreaddata, 32'h0000_0000);
`else
        c1 = 32'd0;
        c2 = 32'd0;
        cyc(1'b1, A_CY, 32'h0000_1234, 1'b0);
        cyc(1'b0, A_CY, 32'd0, 1'b0);
        check("cycles_absent", memreaddata, c1 | c2);
`endif

        // Reset with a same-cycle LED write and TX push: both suppressed
        cyc(1'b1, A_TX, 32'h0000_0099, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0);
        check("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1; memwrite = 1'b1; memaddr = A_LED; memwritedata = 32'h0000_00FF;
        @(posedge clk);
        #1 reset = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        check("reset_led_clear", {24'd0, led}, 32'd0);
        check("reset_fifo_clear", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data_clear", {24'd0, tx_data}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
